// File: rtl/unified_memory_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants for unified_memory: default port widths and the boot
// program that is loaded into the low words of the array on reset when the
// boot-ROM build option (UNIFIED_MEMORY_BOOT_ROM_EN) is enabled.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 30;
    localparam int BOOT_LEN       = 14;

    localparam logic [31:0] BOOT_PROGRAM [BOOT_LEN] = '{
        32'h24020005, 32'h24030007, 32'h24040002, 32'h24050003,
        32'h00430820, 32'h00A42822, 32'h00623824, 32'h8C0A0010,
        32'h00624025, 32'h00624826, 32'h00423827, 32'h24020004,
        32'h24030005, 32'h24040006
    };

    // Boot image word for a given array index; words past the program are zero.
    function automatic logic [31:0] boot_word(input int idx);
        logic [31:0] w;
        if (idx < BOOT_LEN) begin
            w = BOOT_PROGRAM[idx];
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

endpackage

// File: rtl/unified_memory_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Picks which of the two requesters (fetch / data) owns the single array
// access this cycle. Data wins contention unless fetch has already been
// denied STARVE_LIMIT consecutive cycles, in which case fetch is forced
// through.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_req, d_req       fetch / data requests
//   if_grant, d_grant   combinational grants (at most one high)
//   if_stall, d_stall   requester asked but was not granted this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    output logic if_grant,
    output logic d_grant,
    output logic if_stall,
    output logic d_stall
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             fetch_prio_s;

    // Grant selection and stall flags from current requests and starve count.
    always_comb begin
        fetch_prio_s = (starve_q == LIMIT);
        if (if_req && d_req) begin
            if_grant = fetch_prio_s;
            d_grant  = ~fetch_prio_s;
        end else begin
            if_grant = if_req;
            d_grant  = d_req;
        end
        if_stall = if_req & ~if_grant;
        d_stall  = d_req & ~d_grant;
    end

    // Starvation counter next state: counts consecutive fetch denials, saturating.
    always_comb begin
        if (if_req && !if_grant) begin
            if (starve_q == LIMIT) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + CNT_W'(1);
            end
        end else begin
            starve_d = '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/unified_memory.sv
// -----------------------------------------------------------------------------
// unified_memory
// Single-array instruction/data memory shared by the fetch and memory stages.
// One array access per cycle, registered read (one-cycle latency), byte-enabled
// writes with read-before-write data returned, range check against DEPTH.
// Build option: define UNIFIED_MEMORY_BOOT_ROM_EN to reload the boot program
// (mem_pkg::BOOT_PROGRAM) into words 0..BOOT_LEN-1 and zero the rest on every
// reset cycle. Without it the array is zero at time 0 and survives reset.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request and word address
//   if_stall                    fetch not granted (combinational)
//   if_valid/if_rdata           fetched word, registered
//   d_req/d_wren/d_be/d_addr/d_wdata   data request, write flag, byte enables
//   d_stall                     data not granted (combinational)
//   d_valid/d_rdata             data read / pre-write word, registered
//   addr_fault                  completing access was out of range, registered
// -----------------------------------------------------------------------------
module unified_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_stall,
    output logic                    if_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_wren,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_stall,
    output logic                    d_valid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    addr_fault
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  if_grant_s;
    logic                  d_grant_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic                  acc_in_range_s;
    logic [IDX_W-1:0]      acc_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] wr_word_s;
    logic                  wr_en_s;

    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  addr_fault_q, addr_fault_d;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .if_grant (if_grant_s),
        .d_grant  (d_grant_s),
        .if_stall (if_stall),
        .d_stall  (d_stall)
    );

    // Single shared access path: address mux, range check, array read, byte merge.
    always_comb begin
        if (d_grant_s) begin
            acc_addr_s = d_addr;
        end else begin
            acc_addr_s = if_addr;
        end
        acc_in_range_s = ({1'b0, acc_addr_s} < DEPTH_A);
        acc_idx_s      = acc_addr_s[IDX_W-1:0];
        if (acc_in_range_s) begin
            rd_word_s = mem_q[acc_idx_s];
        end else begin
            rd_word_s = '0;
        end
        for (int b = 0; b < BE_W; b++) begin
            if (d_be[b]) begin
                wr_word_s[8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
                wr_word_s[8*b +: 8] = rd_word_s[8*b +: 8];
            end
        end
        // A write granted in a reset cycle is dropped.
        wr_en_s = d_grant_s & d_wren & acc_in_range_s & ~reset;
    end

    // Next state of the port result registers; rdata holds when not granted.
    always_comb begin
        if_valid_d   = if_grant_s;
        d_valid_d    = d_grant_s;
        addr_fault_d = (if_grant_s | d_grant_s) & ~acc_in_range_s;
        if (if_grant_s) begin
            if_rdata_d = rd_word_s;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        if (d_grant_s) begin
            d_rdata_d = rd_word_s;
        end else begin
            d_rdata_d = d_rdata_q;
        end
    end

    // Port result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_valid_q    <= 1'b0;
            d_rdata_q    <= '0;
            addr_fault_q <= 1'b0;
        end else begin
            if_valid_q   <= if_valid_d;
            if_rdata_q   <= if_rdata_d;
            d_valid_q    <= d_valid_d;
            d_rdata_q    <= d_rdata_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    // Storage array: byte-merged write, optional boot image reload on reset.
    always_ff @(posedge clk) begin
`ifdef UNIFIED_MEMORY_BOOT_ROM_EN
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(boot_word(i));
            end
        end else if (wr_en_s) begin
            mem_q[acc_idx_s] <= wr_word_s;
        end
`else
        if (wr_en_s) begin
            mem_q[acc_idx_s] <= wr_word_s;
        end
`endif
    end

    assign if_valid   = if_valid_q;
    assign if_rdata   = if_rdata_q;
    assign d_valid    = d_valid_q;
    assign d_rdata    = d_rdata_q;
    assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_unified_memory.sv
module tb_unified_memory;

    localparam int DW    = 32;
    localparam int AW    = 30;
    localparam int DEPTH = 64;
    localparam int LIMIT = 3;

    localparam logic [31:0] BOOT [14] = '{
        32'h24020005, 32'h24030007, 32'h24040002, 32'h24050003,
        32'h00430820, 32'h00A42822, 32'h00623824, 32'h8C0A0010,
        32'h00624025, 32'h00624826, 32'h00423827, 32'h24020004,
        32'h24030005, 32'h24040006
    };

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_stall;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_wren;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_stall;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          addr_fault;

    always #5 clk = ~clk;

    unified_memory #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_stall   (if_stall),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_wren     (d_wren),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_stall    (d_stall),
        .d_valid    (d_valid),
        .d_rdata    (d_rdata),
        .addr_fault (addr_fault)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_denied = 0;
    bit          e_if_valid = 1'b0;
    bit          e_d_valid  = 1'b0;
    bit          e_fault    = 1'b0;
    logic [31:0] e_if_rdata = 32'h0;
    logic [31:0] e_d_rdata  = 32'h0;
    bit          g_if = 1'b0;
    bit          g_d  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        if (a < AW'(DEPTH)) return m_mem[a[5:0]];
        return 32'h0;
    endfunction

    // One clock cycle: apply inputs, check stalls, advance model, check results.
    task automatic cycle(input bit rst, input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit dw, input logic [3:0] be,
                         input logic [AW-1:0] da, input logic [31:0] wd);
        bit gi;
        bit gd;
        reset   = rst;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_wren  = dw;
        d_be    = be;
        d_addr  = da;
        d_wdata = wd;
        #1;
        if (ir && dr) begin
            gd = (m_denied != LIMIT);
            gi = !gd;
        end else begin
            gi = ir;
            gd = dr;
        end
        check_eq("if_stall", 32'(if_stall), 32'(ir && !gi));
        check_eq("d_stall",  32'(d_stall),  32'(dr && !gd));
        g_if = gi;
        g_d  = gd;
        if (rst) begin
            m_denied   = 0;
            e_if_valid = 1'b0;
            e_d_valid  = 1'b0;
            e_fault    = 1'b0;
            e_if_rdata = 32'h0;
            e_d_rdata  = 32'h0;
`ifdef UNIFIED_MEMORY_BOOT_ROM_EN
            for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < 14) ? BOOT[i] : 32'h0;
`endif
        end else begin
            if (ir && !gi) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
            else           m_denied = 0;
            e_if_valid = gi;
            e_d_valid  = gd;
            e_fault    = 1'b0;
            if (gi) begin
                e_if_rdata = m_read(ia);
                e_fault    = (ia >= AW'(DEPTH));
            end
            if (gd) begin
                e_d_rdata = m_read(da);
                e_fault   = (da >= AW'(DEPTH));
                if (dw && da < AW'(DEPTH)) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_mem[da[5:0]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("if_valid",   32'(if_valid),   32'(e_if_valid));
        check_eq("if_rdata",   if_rdata,        e_if_rdata);
        check_eq("d_valid",    32'(d_valid),    32'(e_d_valid));
        check_eq("d_rdata",    d_rdata,         e_d_rdata);
        check_eq("addr_fault", 32'(addr_fault), 32'(e_fault));
    endtask

    initial begin
        bit          pi  = 1'b0;
        bit          pd  = 1'b0;
        bit          pw  = 1'b0;
        logic [AW-1:0] pia = '0;
        logic [AW-1:0] pda = '0;
        logic [3:0]  pbe = 4'h0;
        logic [31:0] pwd = 32'h0;
        bit          rs;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wren = 1'b0;
        d_be = 4'h0; d_addr = '0; d_wdata = 32'h0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, 1'b0, 30'd0, 1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        cycle(1'b1, 1'b0, 30'd0, 1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        check_eq("rst_if_valid", 32'(if_valid), 32'h0);
        check_eq("rst_d_rdata",  d_rdata,       32'h0);

        // Boot read / fetch of words 0..2
        for (int a = 0; a < 3; a++) begin
            cycle(1'b0, 1'b1, 30'(a), 1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
`ifdef UNIFIED_MEMORY_BOOT_ROM_EN
            check_eq("boot_word", if_rdata, BOOT[a]);
`endif
        end
        cycle(1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 4'h0, 30'd0, 32'h0);

        // Byte-enabled writes to 20, then read back
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 4'hF, 30'd20, 32'hAABBCCDD);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 4'h5, 30'd20, 32'h11223344);
        check_eq("bw_prewrite", d_rdata, 32'hAABBCCDD);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 4'h0, 30'd20, 32'h0);
        check_eq("bw_merge", d_rdata, 32'hAA22CC44);

        // Contention: both held high, data x3 then fetch, repeating
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 30'd3, 1'b1, 1'b0, 4'h0, 30'd20, 32'h0);
            check_eq("starve_pat_if", 32'(if_valid), 32'((k % 4) == 3));
        end

        // Out of range write then read, word 0 unaffected
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 4'hF, 30'd64, 32'hFFFFFFFF);
        check_eq("oor_wr_fault", 32'(addr_fault), 32'h1);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 4'h0, 30'd64, 32'h0);
        check_eq("oor_rd_data", d_rdata, 32'h0);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 4'h0, 30'd0, 32'h0);

        // Reset asserted in the cycle a write to 5 is granted
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 30'd0, 1'b1, 1'b1, 4'hF, 30'd5, 32'h12345678);
        check_eq("rst_mid_valid", 32'(d_valid), 32'h0);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 4'h0, 30'd5, 32'h0);
`ifdef UNIFIED_MEMORY_BOOT_ROM_EN
        check_eq("rst_mid_word", d_rdata, 32'h00A42822);
`else
        check_eq("rst_mid_word", d_rdata, 32'hDEADBEEF);
`endif

        // Back-to-back write then read of the same address
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 4'hF, 30'd10, 32'h12345678);
        cycle(1'b0, 1'b0, 30'd0, 1'b1, 1'b0, 4'h0, 30'd10, 32'h0);
        check_eq("b2b_read", d_rdata, 32'h12345678);

        // Randomized traffic; a denied requester keeps its request unchanged
        for (int k = 0; k < 500; k++) begin
            if (!pi || g_if) begin
                pi  = ($urandom_range(0, 3) != 0);
                pia = 30'($urandom_range(0, 67));
            end
            if (!pd || g_d) begin
                pd  = ($urandom_range(0, 3) != 0);
                pda = ($urandom_range(0, 1) == 1) ? 30'($urandom_range(0, 7))
                                                  : 30'($urandom_range(0, 67));
                pw  = ($urandom_range(0, 1) == 1);
                pbe = 4'($urandom_range(0, 15));
                pwd = $urandom;
            end
            rs = ($urandom_range(0, 60) == 0);
            cycle(rs, pi, pia, pd, pw, pbe, pda, pwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
